conv_tile_scheduler: RTL
========================

CONV_TILE_SCHEDULER -- requirements
Module: conv_tile_scheduler

Interface
REQ-001 Parameter S2P_SIZE, 8, outputs per GEMM tile; power of two, at least 2.
REQ-002 Parameter TENSOR_W, 8, width of tensor_size.
REQ-003 Parameter ADDR_W, 16, width of result-address outputs.
REQ-004 Parameter KGRP_W, 8, width of the kernel-group count.
REQ-005 clk  in  1  clock; all state on rising edge.
REQ-006 rstn  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle request to begin a convolution; ignored unless IDLE.
REQ-008 tensor_size  in  TENSOR_W  input feature edge T; sampled on accepted start.
REQ-009 kernel_size  in  4  kernel edge K; sampled on accepted start.
REQ-010 stride  in  3  stride S; sampled on accepted start.
REQ-011 kgrp_num  in  KGRP_W  number of kernel groups G; sampled on accepted start.
REQ-012 tile_req  out  1  request GEMM to run the current tile.
REQ-013 tile_ack  in  1  GEMM accepted the request.
REQ-014 tile_done  in  1  one-cycle pulse: GEMM finished the accepted tile.
REQ-015 tile_idx  out  ADDR_W  current tile index, 0-based.
REQ-016 kgrp_idx  out  KGRP_W  current kernel group index, 0-based.
REQ-017 last_tile  out  1  high while tile_idx is the last tile of the group.
REQ-018 switch_kernel_group_addnums  out  ADDR_W  registered F*S2P_SIZE-(N-1)*S2P_SIZE.
REQ-019 switch_kernel_addnums  out  ADDR_W  registered F-S2P_SIZE+1.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 conv_done  out  1  one-cycle pulse at end of the convolution.
REQ-022 err_cfg  out  1  one-cycle pulse on an illegal configuration.
REQ-023 perf_stall_cycles  out  16  handshake stall counter (see Configuration).

Function
REQ-024 States are IDLE, CALC, MUL, ISSUE, WAIT and DONE.
REQ-025 IDLE: start captures T, K, S and G.
REQ-026 IDLE: if K>T, S==0 or G==0, the FSM pulses err_cfg next cycle and stays IDLE; otherwise it goes to CALC.
REQ-027 CALC: an accumulator is loaded with T-K and a quotient with 0; each cycle, while the accumulator is >=S, it subtracts S and increments the quotient; when the accumulator is <S, O=quotient+1 and the FSM goes to MUL.
REQ-028 MUL (one cycle) registers:
- F=O*O
- N=ceil(F/S2P_SIZE), computed by shift
- both addnums outputs.
All are computed at ADDR_W width, truncated.
REQ-029 MUL clears tile_idx and kgrp_idx, then goes to ISSUE.
REQ-030 ISSUE: tile_req is high; on tile_ack the FSM goes to WAIT and tile_req drops the next cycle.
REQ-031 WAIT: on tile_done, the FSM advances:
- if tile_idx<N-1: tile_idx+1.
- else if kgrp_idx<G-1: tile_idx=0, kgrp_idx+1.
- else: go to DONE.
REQ-032 After a non-final tile_done, the FSM returns to ISSUE.
REQ-033 tile_done outside WAIT is ignored; tile_ack outside ISSUE is ignored.
REQ-034 tile_ack and tile_done in the same WAIT cycle: only tile_done is used.
REQ-035 DONE lasts one cycle: conv_done=1, then IDLE; tile_idx, kgrp_idx and the addnums hold their values until the next start.
REQ-036 start while busy has no effect; sampled configuration does not change mid-run.
REQ-037 Total tile_req handshakes per run equal N*G exactly.

Reset
REQ-038 rstn low forces IDLE asynchronously, at any point including mid-operation; no pending handshake is resumed.
REQ-039 rstn low clears all outputs to 0: tile_req, busy, conv_done, err_cfg, tile_idx, kgrp_idx, last_tile, both addnums, perf_stall_cycles.
REQ-040 rstn low clears all internal registers to 0.

Configuration
REQ-041 Macro SCHED_PERF_CNT_EN.
REQ-042 With SCHED_PERF_CNT_EN defined: perf_stall_cycles counts cycles with tile_req=1 and tile_ack=0, saturates at 16'hFFFF, and clears on accepted start.
REQ-043 Without SCHED_PERF_CNT_EN: the port exists, is tied to 0, and no counter logic is built.

Verification
REQ-044 T=8,K=3,S=1,G=2, ack and done immediately -> O=6, F=36, N=5, group addnums=256, kernel addnums=29; 10 handshakes; conv_done once after the 10th tile_done.
REQ-045 T=7,K=3,S=2,G=1 -> N=2, group addnums=64, kernel addnums=2; last_tile high on tile_idx=1.
REQ-046 K=9,T=8 start -> err_cfg pulse one cycle later; busy and tile_req never assert.
REQ-047 tile_ack held low 5 cycles -> tile_req stays high 5 cycles; perf_stall_cycles=5 with the macro, 0 without.
REQ-048 rstn asserted during WAIT of tile 3 -> all outputs 0 immediately; a new start runs the full sequence from tile 0.
REQ-049 start pulsed during WAIT and a spurious tile_done in ISSUE -> no state or counter change.

Source files
------------

// File: rtl/conv_tile_scheduler.sv
// conv_tile_scheduler: walks GEMM tiles over every kernel group of one convolution.
// Define SCHED_PERF_CNT_EN to build the tile_req stall counter behind perf_stall_cycles.
module conv_tile_scheduler #(
  parameter int S2P_SIZE = 8,
  parameter int TENSOR_W = 8,
  parameter int ADDR_W   = 16,
  parameter int KGRP_W   = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [TENSOR_W-1:0] tensor_size,
  input  logic [3:0]          kernel_size,
  input  logic [2:0]          stride,
  input  logic [KGRP_W-1:0]   kgrp_num,
  output logic                tile_req,
  input  logic                tile_ack,
  input  logic                tile_done,
  output logic [ADDR_W-1:0]   tile_idx,
  output logic [KGRP_W-1:0]   kgrp_idx,
  output logic                last_tile,
  output logic [ADDR_W-1:0]   switch_kernel_group_addnums,
  output logic [ADDR_W-1:0]   switch_kernel_addnums,
  output logic                busy,
  output logic                conv_done,
  output logic                err_cfg,
  output logic [15:0]         perf_stall_cycles
);

  localparam int S2P_LOG2 = $clog2(S2P_SIZE);

  typedef enum logic [2:0] {IDLE, CALC, MUL, ISSUE, WAIT, DONE} state_e;

  state_e              state_q, state_d;
  logic [TENSOR_W-1:0] acc_q, acc_d, quo_q, quo_d;
  logic [2:0]          s_q, s_d;
  logic [KGRP_W-1:0]   g_q, g_d, kgrp_q, kgrp_d;
  logic [ADDR_W-1:0]   n_q, n_d, tile_q, tile_d;
  logic [ADDR_W-1:0]   grp_add_q, grp_add_d, ker_add_q, ker_add_d;
  logic                err_q, err_d;

  logic                start_ok, cfg_bad, acc_ge_s, more_tiles, more_groups;
  logic [ADDR_W-1:0]   o_w, f_w, n_w;

  assign start_ok    = (state_q == IDLE) && start;
  assign cfg_bad     = (TENSOR_W'(kernel_size) > tensor_size) || (stride == 3'd0) ||
                       (kgrp_num == '0);
  assign acc_ge_s    = acc_q >= TENSOR_W'(s_q);
  assign more_tiles  = tile_q < (n_q - ADDR_W'(1));
  assign more_groups = kgrp_q < (g_q - KGRP_W'(1));

  // O = floor((T-K)/S)+1 falls out of the repeated-subtraction quotient.
  assign o_w = ADDR_W'(quo_q) + ADDR_W'(1);
  assign f_w = o_w * o_w;
  assign n_w = (f_w + ADDR_W'(S2P_SIZE - 1)) >> S2P_LOG2;

  // NOTE: async reset in the sensitivity list; sequential state uses <= only so all flops update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, otherwise unlisted branches infer latches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = cfg_bad ? IDLE : CALC;
      CALC:    if (!acc_ge_s) state_d = MUL;
      MUL:     state_d = ISSUE;
      ISSUE:   if (tile_ack) state_d = WAIT;
      WAIT:    if (tile_done) state_d = (more_tiles || more_groups) ? ISSUE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tile_req  = 1'b0;
    busy      = 1'b0;
    conv_done = 1'b0;
    if (state_q != IDLE)  busy      = 1'b1;
    if (state_q == ISSUE) tile_req  = 1'b1;
    if (state_q == DONE)  conv_done = 1'b1;
  end

  always_comb begin
    acc_d     = acc_q;
    quo_d     = quo_q;
    s_d       = s_q;
    g_d       = g_q;
    n_d       = n_q;
    tile_d    = tile_q;
    kgrp_d    = kgrp_q;
    grp_add_d = grp_add_q;
    ker_add_d = ker_add_q;
    err_d     = 1'b0;
    if (start_ok) begin
      acc_d = tensor_size - TENSOR_W'(kernel_size);
      quo_d = '0;
      s_d   = stride;
      g_d   = kgrp_num;
      err_d = cfg_bad;
    end
    if (state_q == CALC && acc_ge_s) begin
      acc_d = acc_q - TENSOR_W'(s_q);
      quo_d = quo_q + TENSOR_W'(1);
    end
    if (state_q == MUL) begin
      n_d       = n_w;
      grp_add_d = (f_w << S2P_LOG2) - ((n_w - ADDR_W'(1)) << S2P_LOG2);
      ker_add_d = f_w - ADDR_W'(S2P_SIZE) + ADDR_W'(1);
      tile_d    = '0;
      kgrp_d    = '0;
    end
    if (state_q == WAIT && tile_done) begin
      if (more_tiles) begin
        tile_d = tile_q + ADDR_W'(1);
      end else if (more_groups) begin
        tile_d = '0;
        kgrp_d = kgrp_q + KGRP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q     <= '0;
      quo_q     <= '0;
      s_q       <= '0;
      g_q       <= '0;
      n_q       <= '0;
      tile_q    <= '0;
      kgrp_q    <= '0;
      grp_add_q <= '0;
      ker_add_q <= '0;
      err_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      quo_q     <= quo_d;
      s_q       <= s_d;
      g_q       <= g_d;
      n_q       <= n_d;
      tile_q    <= tile_d;
      kgrp_q    <= kgrp_d;
      grp_add_q <= grp_add_d;
      ker_add_q <= ker_add_d;
      err_q     <= err_d;
    end
  end

  assign tile_idx                    = tile_q;
  assign kgrp_idx                    = kgrp_q;
  assign last_tile                   = (n_q != '0) && (tile_q == n_q - ADDR_W'(1));
  assign switch_kernel_group_addnums = grp_add_q;
  assign switch_kernel_addnums       = ker_add_q;
  assign err_cfg                     = err_q;

`ifdef SCHED_PERF_CNT_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (start_ok) perf_d = '0;
    else if (tile_req && !tile_ack && perf_q != 16'hFFFF) perf_d = perf_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_stall_cycles = perf_q;
`else
  assign perf_stall_cycles = 16'h0000;
`endif

endmodule
